// File: rtl/fifo_rd_packer_if.sv
// Bundle between the packer, the async FIFO read port and the downstream
// packed-word consumer. The packer holds the master modport.
interface fifo_rd_packer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4
);
  logic                         fifo_rd_en;
  logic [DATA_WIDTH-1:0]        fifo_rd_data;
  logic                         fifo_empty;
  logic [PACK*DATA_WIDTH-1:0]   out_data;
  logic [$clog2(PACK):0]        out_beats;
  logic                         out_valid;
  logic                         out_ready;

  // Output stream: a word transfers on any clock edge where out_valid and
  // out_ready are both high; once raised, out_valid, out_data and out_beats
  // stay stable until that transfer, and out_ready is ignored while
  // out_valid is low.
  modport master (
    output fifo_rd_en, out_data, out_beats, out_valid,
    input  fifo_rd_data, fifo_empty, out_ready
  );

  modport slave (
    input  fifo_rd_en, out_data, out_beats, out_valid,
    output fifo_rd_data, fifo_empty, out_ready
  );
endinterface

// File: rtl/fifo_rd_packer.sv
// Pops FIFO words and packs PACK of them LSB-first into one output word.
// Optional partial-word flush on idle timeout: define FIFO_PACK_TIMEOUT_EN.
module fifo_rd_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              rst,
  fifo_rd_packer_if.master  bus,
  output logic [1:0]        dbg_state_o
);
  localparam int CW = $clog2(PACK) + 1;
  localparam int LW = $clog2(PACK);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, OUT = 2'd2} state_e;

  state_e                     state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       pend_q, pend_d;
  logic [PACK*DATA_WIDTH-1:0] data_q, data_d;
  logic [LW-1:0]              lane;
  logic                       pop;

`ifdef FIFO_PACK_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT + 1);
  logic [IW-1:0] idle_q, idle_d;
`endif

  // Gated by rst so no pop is issued while the block is held in reset.
  assign pop = rst && !bus.fifo_empty && (state_q != OUT) &&
               ((int'(cnt_q) + int'(pend_q)) < PACK);
  assign lane = cnt_q[LW-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    pend_d  = pop;
    if (pend_q) begin
      data_d[lane*DATA_WIDTH +: DATA_WIDTH] = bus.fifo_rd_data;
      cnt_d = cnt_q + CW'(1);
    end
    case (state_q)
      IDLE: if (pop) state_d = FILL;
      FILL: begin
        if (pend_q && cnt_q == CW'(PACK - 1)) state_d = OUT;
`ifdef FIFO_PACK_TIMEOUT_EN
        else if (!pend_q && cnt_q != '0 && bus.fifo_empty &&
                 idle_q == IW'(TIMEOUT - 1)) state_d = OUT;
`endif
      end
      OUT: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          cnt_d   = '0;
          data_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef FIFO_PACK_TIMEOUT_EN
  // Counts consecutive capture-free cycles spent in FILL; saturates.
  always_comb begin
    idle_d = idle_q;
    if (state_q != FILL || state_d != FILL || pend_q) idle_d = '0;
    else if (idle_q != IW'(TIMEOUT)) idle_d = idle_q + IW'(1);
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      data_q  <= '0;
`ifdef FIFO_PACK_TIMEOUT_EN
      idle_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
`ifdef FIFO_PACK_TIMEOUT_EN
      idle_q  <= idle_d;
`endif
    end
  end

  assign bus.fifo_rd_en = pop;
  assign bus.out_valid  = (state_q == OUT);
  assign bus.out_beats  = (state_q == OUT) ? cnt_q : '0;
  assign bus.out_data   = data_q;
  assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: a queue-based FIFO and packed-word model,
// directed scenarios plus randomized whole-group traffic.
module tb_fifo_rd_packer;
  localparam int DW      = 8;
  localparam int PACK    = 4;
  localparam int TIMEOUT = 16;
  localparam int OW      = PACK * DW;
  localparam int BW      = $clog2(PACK) + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] dbg_state;

  fifo_rd_packer_if #(.DATA_WIDTH(DW), .PACK(PACK)) bus ();

  fifo_rd_packer #(.DATA_WIDTH(DW), .PACK(PACK), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst_n),
    .bus        (bus.master),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- model state ----------------
  logic [DW-1:0] src_q[$];   // words sitting in the modelled FIFO
  logic [DW-1:0] acc_q[$];   // pushed words not yet forming a full group
  logic [OW-1:0] exp_q[$];   // expected packed words, in order
  logic [BW-1:0] expb_q[$];  // expected out_beats for each packed word

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ready_pct = 100;
  bit gap = 1'b0;
  bit pop_now;

  logic          prev_valid, prev_ready;
  logic [OW-1:0] prev_data, last_hs_data;
  logic [BW-1:0] prev_beats, last_hs_beats;
  int n_pops, n_hs, n_valid_cyc, first_pop_cyc, last_pop_cyc, last_hs_cyc;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void push_word(logic [DW-1:0] w);
    logic [OW-1:0] word;
    src_q.push_back(w);
    acc_q.push_back(w);
    if (acc_q.size() == PACK) begin
      word = '0;
      for (int i = 0; i < PACK; i++) word[i*DW +: DW] = acc_q[i];
      exp_q.push_back(word);
      expb_q.push_back(BW'(PACK));
      acc_q.delete();
    end
  endfunction

  function automatic void flush_partial();
    logic [OW-1:0] word;
    word = '0;
    for (int i = 0; i < acc_q.size(); i++) word[i*DW +: DW] = acc_q[i];
    exp_q.push_back(word);
    expb_q.push_back(BW'(acc_q.size()));
    acc_q.delete();
  endfunction

  function automatic void model_clear();
    src_q.delete();
    acc_q.delete();
    exp_q.delete();
    expb_q.delete();
    prev_valid = 1'b0;
    prev_ready = 1'b0;
  endfunction

  function automatic void update_empty();
    bus.fifo_empty = gap || (src_q.size() == 0);
  endfunction

  // ---------------- per-cycle compare against the model ----------------
  function automatic void monitor();
    if (bus.fifo_empty) check("rd_en_while_empty", 64'(bus.fifo_rd_en), 64'(0));
    if (bus.out_valid) begin
      check("rd_en_during_out", 64'(bus.fifo_rd_en), 64'(0));
      n_valid_cyc++;
    end
    if (prev_valid && !prev_ready) begin
      check("hold_valid", 64'(bus.out_valid), 64'(1));
      check("hold_data", 64'(bus.out_data), 64'(prev_data));
      check("hold_beats", 64'(bus.out_beats), 64'(prev_beats));
    end
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: got 0x%0h, expected no word (cycle %0d)", bus.out_data, cyc);
      end else begin
        check("out_data", 64'(bus.out_data), 64'(exp_q.pop_front()));
        check("out_beats", 64'(bus.out_beats), 64'(expb_q.pop_front()));
      end
      last_hs_data  = bus.out_data;
      last_hs_beats = bus.out_beats;
      last_hs_cyc   = cyc;
      n_hs++;
    end
    if (bus.fifo_rd_en) begin
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
      n_pops++;
    end
    prev_valid = bus.out_valid;
    prev_ready = bus.out_ready;
    prev_data  = bus.out_data;
    prev_beats = bus.out_beats;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(negedge clk);
    cyc++;
    if (rst_n) monitor();
    pop_now = bus.fifo_rd_en && rst_n;
    @(posedge clk);
    #1;
    if (pop_now && rst_n && src_q.size() > 0) bus.fifo_rd_data = src_q.pop_front();
    bus.out_ready = ($urandom_range(0, 99) < ready_pct);
    update_empty();
  endtask

  task automatic drain(int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    check("drain_done", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic wait_valid(int budget);
    int n = 0;
    while (!bus.out_valid && n < budget) begin
      cycle();
      n++;
    end
    check("valid_seen", 64'(bus.out_valid), 64'(1));
  endtask

  task automatic clear_stats();
    n_pops = 0;
    n_hs = 0;
    n_valid_cyc = 0;
    first_pop_cyc = -1;
    last_pop_cyc = -1;
    last_hs_cyc = -1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    bus.fifo_empty = 1'b0;
    bus.fifo_rd_data = '0;
    bus.out_ready = 1'b0;
    model_clear();
    clear_stats();

    // Reset held with a non-empty FIFO: nothing may pop or appear.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_rd_en", 64'(bus.fifo_rd_en), 64'(0));
      check("rst_valid", 64'(bus.out_valid), 64'(0));
      check("rst_data", 64'(bus.out_data), 64'(0));
      check("rst_beats", 64'(bus.out_beats), 64'(0));
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    update_empty();
    bus.out_ready = 1'b1;

    // Full pack with downstream always ready.
    ready_pct = 100;
    clear_stats();
    push_word(8'h11); push_word(8'h22); push_word(8'h33); push_word(8'h44);
    update_empty();
    drain(40);
    repeat (3) cycle();
    check("full_pops", 64'(n_pops), 64'(4));
    check("full_data", 64'(last_hs_data), 64'h44332211);
    check("full_beats", 64'(last_hs_beats), 64'(4));
    check("full_valid_cycles", 64'(n_valid_cyc), 64'(1));
    check("full_latency", 64'(last_hs_cyc - first_pop_cyc), 64'(PACK + 1));

    // Backpressure: first word must sit stable with no pops.
    ready_pct = 0;
    clear_stats();
    for (int i = 1; i <= 8; i++) push_word(DW'(i));
    update_empty();
    wait_valid(40);
    repeat (10) cycle();
    check("bp_pops_during_stall", 64'(n_pops), 64'(4));
    check("bp_stall_data", 64'(bus.out_data), 64'h04030201);
    ready_pct = 100;
    drain(60);
    check("bp_second_data", 64'(last_hs_data), 64'h08070605);

`ifndef FIFO_PACK_TIMEOUT_EN
    // FIFO runs dry mid-fill: partial lanes must wait.
    clear_stats();
    push_word(8'hAA); push_word(8'hBB);
    update_empty();
    repeat (30) cycle();
    check("gap_no_output", 64'(n_valid_cyc), 64'(0));
    check("gap_pops", 64'(n_pops), 64'(2));
    push_word(8'hCC); push_word(8'hDD);
    update_empty();
    drain(40);
    check("gap_data", 64'(last_hs_data), 64'hDDCCBBAA);
`else
    // Partial word flushed after TIMEOUT idle cycles.
    clear_stats();
    push_word(8'h01); push_word(8'h02); push_word(8'h03);
    flush_partial();
    update_empty();
    drain(60);
    check("to_data", 64'(last_hs_data), 64'h00030201);
    check("to_beats", 64'(last_hs_beats), 64'(3));
    check("to_latency", 64'(last_hs_cyc - last_pop_cyc), 64'(TIMEOUT + 2));
`endif

    // Asynchronous reset after two captures.
    clear_stats();
    push_word(8'h51); push_word(8'h52);
    update_empty();
    repeat (4) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(bus.out_valid), 64'(0));
    check("arst_data", 64'(bus.out_data), 64'(0));
    check("arst_rd_en", 64'(bus.fifo_rd_en), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    clear_stats();
    push_word(8'h61); push_word(8'h62); push_word(8'h63); push_word(8'h64);
    update_empty();
    drain(40);
    check("arst_next_data", 64'(last_hs_data), 64'h64636261);

    // Randomized whole-group traffic with random downstream readiness.
    ready_pct = 70;
    for (int r = 0; r < 25; r++) begin
      int groups;
      groups = $urandom_range(1, 2);
      for (int w = 0; w < groups * PACK; w++) push_word(DW'($urandom_range(0, 255)));
      update_empty();
      repeat ($urandom_range(0, 12)) cycle();
    end
    drain(3000);
    check("rand_fifo_drained", 64'(src_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
